// File: rtl/unidade_controle_mc_pkg.sv
// uc_pkg: shared types and encodings for the multicycle control unit.
//   state_t    - 5-bit FSM state codes (also exported on state_o for debug)
//   alu_fct_t  - ALU operation codes driven on alu_fct
//   OP_*/F3_*  - instruction field encodings recognised by DECODE
//   PC_*, M2R_*, A_*, B_* - datapath mux select codes
//   CAUSE_*    - trap cause codes
package uc_pkg;

   typedef enum logic [4:0] {
      S_RESET   = 5'd0,
      S_FETCH   = 5'd1,
      S_DECODE  = 5'd2,
      S_MEMADDR = 5'd3,
      S_MEMRD   = 5'd4,
      S_MEMWB   = 5'd5,
      S_MEMWR   = 5'd6,
      S_EXE_R   = 5'd7,
      S_EXE_I   = 5'd8,
      S_WB_ALU  = 5'd9,
      S_BRANCH  = 5'd10,
      S_LUI     = 5'd11,
      S_JAL     = 5'd12,
      S_TRAP    = 5'd13
   } state_t;

   typedef enum logic [2:0] {
      FCT_PASS = 3'd0,
      FCT_ADD  = 3'd1,
      FCT_SUB  = 3'd2,
      FCT_AND  = 3'd3,
      FCT_OR   = 3'd4,
      FCT_SLT  = 3'd6
   } alu_fct_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_DW  = 3'b011;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_BLT = 3'b100;
   localparam logic [2:0] F3_BGE = 3'b101;

   localparam logic [1:0] PC_ALU  = 2'd0;
   localparam logic [1:0] PC_AOUT = 2'd1;
   localparam logic [1:0] PC_TRAP = 2'd2;

   localparam logic [1:0] M2R_AOUT = 2'd0;
   localparam logic [1:0] M2R_MDR  = 2'd1;
   localparam logic [1:0] M2R_IMM  = 2'd2;
   localparam logic [1:0] M2R_PC   = 2'd3;

   localparam logic [1:0] A_PC  = 2'd0;
   localparam logic [1:0] A_REG = 2'd1;

   localparam logic [1:0] B_REG  = 2'd0;
   localparam logic [1:0] B_4    = 2'd1;
   localparam logic [1:0] B_IMM  = 2'd2;
   localparam logic [1:0] B_IMM1 = 2'd3;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_ILL  = 2'd1;
   localparam logic [1:0] CAUSE_TMO  = 2'd2;

   // R-type operation; FCT_PASS doubles as "not a supported encoding".
   function automatic alu_fct_t r_fct(input logic [2:0] f3, input logic [6:0] f7);
      case ({f7, f3})
         10'b0000000_000: r_fct = FCT_ADD;
         10'b0100000_000: r_fct = FCT_SUB;
         10'b0000000_111: r_fct = FCT_AND;
         10'b0000000_110: r_fct = FCT_OR;
         10'b0000000_010: r_fct = FCT_SLT;
         default:         r_fct = FCT_PASS;
      endcase
   endfunction

   // I-type operation (addi/slti only); FCT_PASS means unsupported.
   function automatic alu_fct_t i_fct(input logic [2:0] f3);
      case (f3)
         3'b000:  i_fct = FCT_ADD;
         3'b010:  i_fct = FCT_SLT;
         default: i_fct = FCT_PASS;
      endcase
   endfunction

   function automatic logic br_legal(input logic [2:0] f3);
      br_legal = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
   endfunction

endpackage

// File: rtl/unidade_controle_mc_if.sv
// uc_mem_if: memory request/ready handshake between control unit and memory.
//   mem_req   - access requested this cycle (master -> slave)
//   mem_we    - access is a write           (master -> slave)
//   mem_ready - access completed this cycle (slave -> master)
interface uc_mem_if;
   logic mem_req;
   logic mem_we;
   logic mem_ready;

   modport master (output mem_req, output mem_we, input mem_ready);
   modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/unidade_controle_mc_wait_timer.sv
// uc_wait_timer: counts consecutive cycles a memory access is left waiting.
//   clk, reset  - clock / async active-low reset
//   wait_i      - FSM is in a state that waits on mem_ready
//   ready_i     - mem_ready this cycle
//   expired_o   - this waiting cycle is the MEM_TIMEOUT-th without ready
// The counter is zero whenever the FSM is outside a wait state or the access
// completes, so every entry into a wait state starts from zero.
module uc_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic wait_i,
   input  logic ready_i,
   output logic expired_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!wait_i || ready_i)  cnt_d = 8'd0;
      else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

   // Fires on the cycle the count would reach MEM_TIMEOUT; ready in that
   // same cycle suppresses it so the access completes instead.
   assign expired_o = (MEM_TIMEOUT != 0) && wait_i && !ready_i &&
                      (({1'b0, cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT));

endmodule

// File: rtl/unidade_controle_mc.sv
// unidade_controle_mc: multicycle control FSM for the RV64 datapath.
//   clk, reset                 - clock / async active-low reset
//   opcode, func3, func7       - IR decode fields
//   alu_zero, alu_lt           - ALU flags used for branch resolution
//   mem (uc_mem_if.master)     - mem_req / mem_we out, mem_ready in
//   state_o                    - current state (debug)
//   ir_load..load_epc          - datapath register enables
//   pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_fct - mux selects / ALU op
//   trap, trap_cause           - trap entry pulse / latched cause
module unidade_controle_mc
   import uc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned ALU_FCT_W   = 3,
   parameter int unsigned ENABLE_JAL  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [6:0]           opcode,
   input  logic [2:0]           func3,
   input  logic [6:0]           func7,
   input  logic                 alu_zero,
   input  logic                 alu_lt,
   uc_mem_if.master             mem,
   output logic [4:0]           state_o,
   output logic                 ir_load,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic                 load_a,
   output logic                 load_b,
   output logic                 load_aout,
   output logic                 load_mdr,
   output logic                 load_epc,
   output logic [1:0]           pc_src,
   output logic [1:0]           mem_to_reg,
   output logic [1:0]           alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [ALU_FCT_W-1:0] alu_fct,
   output logic                 trap,
   output logic [1:0]           trap_cause
);

   state_t     state_q, state_d;
   logic [1:0] trap_cause_q, cause_d;
   logic       in_wait, tmo_expired;
   alu_fct_t   fct_c;

   assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

   uc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .wait_i    (in_wait),
      .ready_i   (mem.mem_ready),
      .expired_o (tmo_expired)
   );

   // State register; trap_cause is latched on entry so it is already valid
   // during the TRAP cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_RESET;
         trap_cause_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= cause_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cause_d = trap_cause_q;
      case (state_q)
         S_RESET: state_d = S_FETCH;
         S_FETCH, S_MEMRD, S_MEMWR: begin
            if (mem.mem_ready) begin
               state_d = (state_q == S_FETCH) ? S_DECODE :
                         (state_q == S_MEMRD) ? S_MEMWB  : S_FETCH;
            end else if (tmo_expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TMO;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R:         state_d = (r_fct(func3, func7) != FCT_PASS) ? S_EXE_R : S_TRAP;
               OP_I:         state_d = (i_fct(func3) != FCT_PASS) ? S_EXE_I : S_TRAP;
               OP_LD, OP_SD: state_d = (func3 == F3_DW) ? S_MEMADDR : S_TRAP;
               OP_BR:        state_d = br_legal(func3) ? S_BRANCH : S_TRAP;
               OP_LUI:       state_d = S_LUI;
               OP_JAL:       state_d = (ENABLE_JAL != 0) ? S_JAL : S_TRAP;
               default:      state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP) cause_d = CAUSE_ILL;
         end
         S_MEMADDR:        state_d = (opcode == OP_SD) ? S_MEMWR : S_MEMRD;
         S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
         default:          state_d = S_FETCH;  // single-cycle states and unused codes
      endcase
   end

   always_comb begin
      mem.mem_req = 1'b0;
      mem.mem_we  = 1'b0;
      ir_load     = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      load_a      = 1'b0;
      load_b      = 1'b0;
      load_aout   = 1'b0;
      load_mdr    = 1'b0;
      load_epc    = 1'b0;
      pc_src      = PC_ALU;
      mem_to_reg  = M2R_AOUT;
      alu_src_a   = A_PC;
      alu_src_b   = B_REG;
      fct_c       = FCT_PASS;
      trap        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem.mem_req = 1'b1;
            alu_src_b   = B_4;
            fct_c       = FCT_ADD;
            ir_load     = mem.mem_ready;
            pc_write    = mem.mem_ready;
         end
         S_DECODE: begin
            // Speculative branch target PC + (imm<<1) parked in AluOut.
            load_a    = 1'b1;
            load_b    = 1'b1;
            load_aout = 1'b1;
            alu_src_b = B_IMM1;
            fct_c     = FCT_ADD;
         end
         S_MEMADDR: begin
            alu_src_a = A_REG;
            alu_src_b = B_IMM;
            fct_c     = FCT_ADD;
            load_aout = 1'b1;
         end
         S_MEMRD: begin
            mem.mem_req = 1'b1;
            load_mdr    = mem.mem_ready;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_MDR;
         end
         S_MEMWR: begin
            mem.mem_req = 1'b1;
            mem.mem_we  = 1'b1;
         end
         S_EXE_R: begin
            alu_src_a = A_REG;
            fct_c     = r_fct(func3, func7);
            load_aout = 1'b1;
         end
         S_EXE_I: begin
            alu_src_a = A_REG;
            alu_src_b = B_IMM;
            fct_c     = i_fct(func3);
            load_aout = 1'b1;
         end
         S_WB_ALU: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = A_REG;
            fct_c     = FCT_SUB;
            pc_src    = PC_AOUT;
            case (func3)
               F3_BEQ:  pc_write = alu_zero;
               F3_BNE:  pc_write = !alu_zero;
               F3_BLT:  pc_write = alu_lt;
               F3_BGE:  pc_write = !alu_lt;
               default: pc_write = 1'b0;
            endcase
         end
         S_LUI: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_IMM;
         end
         S_JAL: begin
            reg_write  = 1'b1;
            mem_to_reg = M2R_PC;
            pc_write   = 1'b1;
            pc_src     = PC_AOUT;
         end
         S_TRAP: begin
            trap     = 1'b1;
            load_epc = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_TRAP;
         end
         default: ;
      endcase
   end

   assign state_o    = state_q;
   assign alu_fct    = ALU_FCT_W'(fct_c);
   assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_unidade_controle_mc.sv
module tb_unidade_controle_mc;
   import uc_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode, func7;
   logic [2:0] func3;
   logic       alu_zero, alu_lt;
   logic [4:0] state_o;
   logic       ir_load, pc_write, reg_write, load_a, load_b, load_aout, load_mdr, load_epc, trap;
   logic [1:0] pc_src, mem_to_reg, alu_src_a, alu_src_b, trap_cause;
   logic [2:0] alu_fct;

   uc_mem_if mif();

   unidade_controle_mc #(.MEM_TIMEOUT(4), .ALU_FCT_W(3), .ENABLE_JAL(1)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
      .alu_zero(alu_zero), .alu_lt(alu_lt), .mem(mif), .state_o(state_o),
      .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write), .load_a(load_a),
      .load_b(load_b), .load_aout(load_aout), .load_mdr(load_mdr), .load_epc(load_epc),
      .pc_src(pc_src), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_fct(alu_fct), .trap(trap), .trap_cause(trap_cause)
   );

   always #5 clk = ~clk;

   int npass = 0;
   int ntot  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   typedef struct packed {
      logic [6:0]      op;
      logic [2:0]      f3;
      logic [6:0]      f7;
      logic            z;
      logic            lt;
      logic [2:0]      n;
      logic [4:0][4:0] path;
      logic [2:0]      fct;   // alu_fct in the third cycle
      logic            rw;    // reg_write in the last cycle
      logic            pcw;   // pc_write in the last cycle
   } vec_t;

   function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic z, logic lt,
                               int n, state_t p0, state_t p1, state_t p2, state_t p3, state_t p4,
                               alu_fct_t fct, logic rw, logic pcw);
      vec_t v;
      v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.lt = lt; v.n = 3'(n);
      v.path = {p4, p3, p2, p1, p0};
      v.fct = fct; v.rw = rw; v.pcw = pcw;
      return v;
   endfunction

   localparam int NV = 20;
   vec_t vecs[NV];

   int nreq, nmdr, nrd;

   initial begin
      vecs[0]  = mk(OP_R,   3'b000, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_R,   S_WB_ALU, S_RESET, FCT_ADD,  1, 0);
      vecs[1]  = mk(OP_R,   3'b000, 7'h20, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_R,   S_WB_ALU, S_RESET, FCT_SUB,  1, 0);
      vecs[2]  = mk(OP_R,   3'b111, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_R,   S_WB_ALU, S_RESET, FCT_AND,  1, 0);
      vecs[3]  = mk(OP_R,   3'b110, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_R,   S_WB_ALU, S_RESET, FCT_OR,   1, 0);
      vecs[4]  = mk(OP_R,   3'b010, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_R,   S_WB_ALU, S_RESET, FCT_SLT,  1, 0);
      vecs[5]  = mk(OP_I,   3'b000, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_I,   S_WB_ALU, S_RESET, FCT_ADD,  1, 0);
      vecs[6]  = mk(OP_I,   3'b010, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_EXE_I,   S_WB_ALU, S_RESET, FCT_SLT,  1, 0);
      vecs[7]  = mk(OP_SD,  3'b011, 7'h00, 0, 0, 4, S_FETCH, S_DECODE, S_MEMADDR, S_MEMWR,  S_RESET, FCT_ADD,  0, 0);
      vecs[8]  = mk(OP_LD,  3'b011, 7'h00, 0, 0, 5, S_FETCH, S_DECODE, S_MEMADDR, S_MEMRD,  S_MEMWB, FCT_ADD,  1, 0);
      vecs[9]  = mk(OP_BR,  3'b000, 7'h00, 1, 0, 3, S_FETCH, S_DECODE, S_BRANCH,  S_RESET,  S_RESET, FCT_SUB,  0, 1);
      vecs[10] = mk(OP_BR,  3'b001, 7'h00, 1, 0, 3, S_FETCH, S_DECODE, S_BRANCH,  S_RESET,  S_RESET, FCT_SUB,  0, 0);
      vecs[11] = mk(OP_BR,  3'b100, 7'h00, 0, 1, 3, S_FETCH, S_DECODE, S_BRANCH,  S_RESET,  S_RESET, FCT_SUB,  0, 1);
      vecs[12] = mk(OP_BR,  3'b101, 7'h00, 0, 1, 3, S_FETCH, S_DECODE, S_BRANCH,  S_RESET,  S_RESET, FCT_SUB,  0, 0);
      vecs[13] = mk(OP_BR,  3'b101, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_BRANCH,  S_RESET,  S_RESET, FCT_SUB,  0, 1);
      vecs[14] = mk(OP_LUI, 3'b000, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_LUI,     S_RESET,  S_RESET, FCT_PASS, 1, 0);
      vecs[15] = mk(OP_JAL, 3'b000, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_JAL,     S_RESET,  S_RESET, FCT_PASS, 1, 1);
      vecs[16] = mk(7'h7F,  3'b000, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_TRAP,    S_RESET,  S_RESET, FCT_PASS, 0, 1);
      vecs[17] = mk(OP_R,   3'b111, 7'h20, 0, 0, 3, S_FETCH, S_DECODE, S_TRAP,    S_RESET,  S_RESET, FCT_PASS, 0, 1);
      vecs[18] = mk(OP_LD,  3'b010, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_TRAP,    S_RESET,  S_RESET, FCT_PASS, 0, 1);
      vecs[19] = mk(OP_I,   3'b001, 7'h00, 0, 0, 3, S_FETCH, S_DECODE, S_TRAP,    S_RESET,  S_RESET, FCT_PASS, 0, 1);

      // Reset: every output zero while reset is low.
      reset = 1'b0; opcode = 7'h0; func3 = 3'h0; func7 = 7'h0;
      alu_zero = 1'b0; alu_lt = 1'b0; mif.mem_ready = 1'b0;
      @(negedge clk); #1;
      chk("rst_state", 32'(state_o), 32'(S_RESET));
      chk("rst_outs", 32'({mif.mem_req, mif.mem_we, ir_load, pc_write, reg_write, load_a, load_b,
                           load_aout, load_mdr, load_epc, pc_src, mem_to_reg, alu_src_a, alu_src_b,
                           alu_fct, trap, trap_cause}), 32'd0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);

      // Table: each vector starts in FETCH with mem_ready high.
      for (int i = 0; i < NV; i++) begin
         opcode = vecs[i].op; func3 = vecs[i].f3; func7 = vecs[i].f7;
         alu_zero = vecs[i].z; alu_lt = vecs[i].lt; mif.mem_ready = 1'b1;
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            #1;
            chk($sformatf("v%0d_state%0d", i, k), 32'(state_o), 32'(vecs[i].path[k]));
            if (k == 2) chk($sformatf("v%0d_fct", i), 32'(alu_fct), 32'(vecs[i].fct));
            if (k == int'(vecs[i].n) - 1) begin
               chk($sformatf("v%0d_rw", i), 32'(reg_write), 32'(vecs[i].rw));
               chk($sformatf("v%0d_pcw", i), 32'(pc_write), 32'(vecs[i].pcw));
            end
            @(negedge clk);
         end
      end

      // Illegal opcode: single trap pulse with cause 1, EPC load, trap vector.
      opcode = 7'h7F; mif.mem_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      chk("ill_state", 32'(state_o), 32'(S_TRAP));
      chk("ill_trap", 32'({trap, load_epc, pc_write, pc_src}), 32'({1'b1, 1'b1, 1'b1, PC_TRAP}));
      chk("ill_cause", 32'(trap_cause), 32'(CAUSE_ILL));
      @(negedge clk); #1;
      chk("ill_after", 32'({state_o, trap}), 32'({S_FETCH, 1'b0}));
      chk("ill_held", 32'(trap_cause), 32'(CAUSE_ILL));

      // Timeout in FETCH: 4 waiting cycles then TRAP with cause 2.
      mif.mem_ready = 1'b0; opcode = OP_R; func3 = 3'b000; func7 = 7'h00;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("tmo_wait%0d", c), 32'({state_o, mif.mem_req}), 32'({S_FETCH, 1'b1}));
         @(negedge clk);
      end
      #1;
      chk("tmo_state", 32'({state_o, trap}), 32'({S_TRAP, 1'b1}));
      chk("tmo_cause", 32'(trap_cause), 32'(CAUSE_TMO));

      // Ready arriving on the 4th waiting cycle wins over the timeout.
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         #1; chk($sformatf("late_wait%0d", c), 32'(state_o), 32'(S_FETCH));
         @(negedge clk);
      end
      mif.mem_ready = 1'b1; #1;
      chk("late_fetch", 32'({state_o, ir_load}), 32'({S_FETCH, 1'b1}));
      @(negedge clk); #1;
      chk("late_decode", 32'(state_o), 32'(S_DECODE));
      @(negedge clk); @(negedge clk); @(negedge clk);  // EXE_R, WB_ALU, FETCH

      // ld with mem_ready low for 3 cycles in MEMRD.
      opcode = OP_LD; func3 = F3_DW;
      @(negedge clk);           // DECODE
      @(negedge clk);           // MEMADDR
      mif.mem_ready = 1'b0;
      nreq = 0; nmdr = 0; nrd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 3) mif.mem_ready = 1'b1;
         #1;
         if (state_o != 5'(S_MEMRD)) break;
         nrd++; nreq += int'(mif.mem_req); nmdr += int'(load_mdr);
      end
      chk("ld_req_cycles", 32'(nreq), 32'd4);
      chk("ld_mdr_cycles", 32'(nmdr), 32'd1);
      chk("ld_total", 32'(nrd + 3), 32'd7);
      chk("ld_wb", 32'({state_o, reg_write, mem_to_reg}), 32'({S_MEMWB, 1'b1, M2R_MDR}));
      @(negedge clk); #1;
      chk("ld_back", 32'(state_o), 32'(S_FETCH));

      // Reset asserted mid-write: strobes drop immediately, cause clears.
      opcode = OP_SD; func3 = F3_DW;
      @(negedge clk);           // DECODE
      @(negedge clk);           // MEMADDR
      mif.mem_ready = 1'b0;
      @(negedge clk); #1;       // MEMWR
      chk("wr_strobe", 32'({state_o, mif.mem_req, mif.mem_we}), 32'({S_MEMWR, 1'b1, 1'b1}));
      reset = 1'b0; #1;
      chk("wr_drop", 32'({state_o, mif.mem_req, mif.mem_we}), 32'({S_RESET, 1'b0, 1'b0}));
      chk("wr_cause", 32'(trap_cause), 32'(CAUSE_NONE));
      @(negedge clk); reset = 1'b1; mif.mem_ready = 1'b1; #1;
      chk("rel_reset", 32'(state_o), 32'(S_RESET));
      @(negedge clk); #1;
      chk("rel_fetch", 32'({state_o, trap_cause}), 32'({S_FETCH, CAUSE_NONE}));

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
